// File: rtl/qspi_pkg.sv
// Shared QSPI definitions: opcodes, responder FSM states and phase widths.
// Also used by the host-side command select, so keep opcode names stable.
`timescale 1ns/1ps
package qspi_pkg;

  localparam logic [7:0] OP_WREN   = 8'h06;
  localparam logic [7:0] OP_EN4B   = 8'hB7;
  localparam logic [7:0] OP_RDSR   = 8'h05;
  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_QREAD  = 8'hEB;
  localparam logic [7:0] OP_4QREAD = 8'hEC;
  localparam logic [7:0] OP_QPP    = 8'h38;

  localparam int CMD_BITS = 8;
  localparam int CNT_W    = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_STATUS,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_IGNORE
  } resp_state_e;

  // Count value on the final address rise: 3 or 4 bytes, 1 or 4 lines.
  function automatic logic [CNT_W-1:0] addr_last(input logic quad, input logic four);
    int unsigned rises;
    rises = (four ? 4 : 3) * (quad ? 2 : 8);
    return CNT_W'(rises - 1);
  endfunction

endpackage

// File: rtl/qspi_bus_sync.sv
// Two-flop synchronizers for the QSPI bus plus sclk / cs_n edge detection.
`timescale 1ns/1ps
module qspi_bus_sync (
  input  logic       h_clk,
  input  logic       h_rst,
  input  logic       sclk_in,
  input  logic       cs_n_in,
  input  logic [3:0] io_in,
  output logic [3:0] io_s,
  output logic       sclk_rise,
  output logic       sclk_fall,
  output logic       cs_rise,
  output logic       cs_fall
);

  logic [5:0] meta_q, sync_q;
  logic [1:0] prev_q;

  // Chains reset low so a host already holding CS low after reset is not
  // seen as a new transfer; only a genuine CS fall starts one.
  always_ff @(posedge h_clk) begin
    if (h_rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= {cs_n_in, sclk_in, io_in};
      sync_q <= meta_q;
      prev_q <= sync_q[5:4];
    end
  end

  assign io_s      = sync_q[3:0];
  assign sclk_rise =  sync_q[4] & ~prev_q[0];
  assign sclk_fall = ~sync_q[4] &  prev_q[0];
  assign cs_rise   =  sync_q[5] & ~prev_q[1];
  assign cs_fall   = ~sync_q[5] &  prev_q[1];

endmodule

// File: rtl/qspi_flash_responder.sv
// QSPI flash-side responder: decodes WREN/EN4B/RDSR/READ/QREAD/4QREAD/QPP.
// Build option QSPI_RESP_WIP_EN models a BUSY_CYC-long busy window after programs.
`timescale 1ns/1ps
module qspi_flash_responder
  import qspi_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int IDX_W     = 8,
  parameter int DUMMY_CYC = 8,
  parameter int BUSY_CYC  = 64
) (
  input  logic       h_clk,
  input  logic       h_rst,
  input  logic       sclk_in,
  input  logic       cs_n_in,
  input  logic [3:0] io_in,
  output logic [3:0] io_out,
  output logic [3:0] io_oe,
  output logic       addr4_mode_out,
  output logic       wel_out,
  output logic       wip_out,
  output logic       cmd_err_out
);

  localparam int SH_W   = (IDX_W > 8) ? IDX_W : 8;
  localparam int BUSY_W = $clog2(BUSY_CYC + 1);
  localparam logic [IDX_W-1:0] PAGE_MASK = IDX_W'(255);
`ifdef QSPI_RESP_WIP_EN
  localparam bit WIP_EN = 1'b1;
`else
  localparam bit WIP_EN = 1'b0;
`endif

  logic [3:0] io_s;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;

  qspi_bus_sync u_sync (
    .h_clk    (h_clk),
    .h_rst    (h_rst),
    .sclk_in  (sclk_in),
    .cs_n_in  (cs_n_in),
    .io_in    (io_in),
    .io_s     (io_s),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .cs_rise  (cs_rise),
    .cs_fall  (cs_fall)
  );

  resp_state_e      state_q, state_d;
  logic [7:0]       opcode_q, opcode_d, dbyte_q, dbyte_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, addr_last_q, addr_last_d;
  logic [SH_W-1:0]  sh_q, sh_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       dcnt_q, dcnt_d;
  logic [3:0]       io_out_q, io_out_d, io_oe_q, io_oe_d;
  logic [BUSY_W-1:0] busy_q, busy_d;
  logic wr_any_q, wr_any_d, wel_q, wel_d, addr4_q, addr4_d, cmd_err_q, cmd_err_d;

  logic [7:0]       mem_q [MEM_BYTES];
  logic [MEM_BYTES-1:0] vld_q;
  logic             mem_we, wip, addr_quad;
  logic [7:0]       cur_byte, rd_byte, mem_wd, src, obyte;
  logic [SH_W-1:0]  shift1, shift4;
  logic [IDX_W-1:0] page_next;

  assign wip       = WIP_EN && (busy_q != '0);
  assign addr_quad = (opcode_q != OP_READ);
  assign shift1    = SH_W'({sh_q, io_s[0]});
  assign shift4    = SH_W'({sh_q, io_s});
  // Bytes never programmed since reset read as erased flash.
  assign cur_byte  = vld_q[idx_q] ? mem_q[idx_q] : 8'hFF;
  assign rd_byte   = wip ? 8'hFF : cur_byte;
  assign mem_wd    = cur_byte & {dbyte_q[3:0], io_s};
  assign page_next = (idx_q & ~PAGE_MASK) | ((idx_q + IDX_W'(1)) & PAGE_MASK);

  // NOTE: every signal gets a default before any branch, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    cnt_d       = cnt_q;
    addr_last_d = addr_last_q;
    sh_d        = sh_q;
    idx_d       = idx_q;
    dbyte_d     = dbyte_q;
    dcnt_d      = dcnt_q;
    io_out_d    = io_out_q;
    io_oe_d     = io_oe_q;
    wr_any_d    = wr_any_q;
    wel_d       = wel_q;
    addr4_d     = addr4_q;
    cmd_err_d   = 1'b0;
    busy_d      = (busy_q != '0) ? busy_q - BUSY_W'(1) : busy_q;
    mem_we      = 1'b0;
    src         = 8'h00;
    obyte       = 8'h00;

    if (cs_rise) begin
      state_d  = ST_IDLE;
      io_oe_d  = 4'h0;
      io_out_d = 4'h0;
      if (state_q == ST_WR_DATA && wr_any_q) begin
        wel_d = 1'b0;
        if (WIP_EN) busy_d = BUSY_W'(BUSY_CYC);
      end
    end else if (cs_fall) begin
      state_d  = ST_CMD;
      cnt_d    = '0;
      wr_any_d = 1'b0;
      io_oe_d  = 4'h0;
    end else if (sclk_rise) begin
      case (state_q)
        ST_CMD: begin
          sh_d  = shift1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(CMD_BITS - 1)) begin
            opcode_d = shift1[7:0];
            cnt_d    = '0;
            dcnt_d   = '0;
            case (shift1[7:0])
              OP_WREN:   begin wel_d   = 1'b1; state_d = ST_IGNORE; end
              OP_EN4B:   begin addr4_d = 1'b1; state_d = ST_IGNORE; end
              OP_RDSR:   state_d = ST_STATUS;
              OP_READ:   begin state_d = ST_ADDR; addr_last_d = addr_last(1'b0, addr4_q); end
              OP_QREAD:  begin state_d = ST_ADDR; addr_last_d = addr_last(1'b1, addr4_q); end
              OP_4QREAD: begin state_d = ST_ADDR; addr_last_d = addr_last(1'b1, 1'b1); end
              OP_QPP: begin
                state_d     = (wel_q && !wip) ? ST_ADDR : ST_IGNORE;
                addr_last_d = addr_last(1'b1, addr4_q);
              end
              default:   begin cmd_err_d = 1'b1; state_d = ST_IGNORE; end
            endcase
          end
        end
        ST_ADDR: begin
          sh_d  = addr_quad ? shift4 : shift1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == addr_last_q) begin
            idx_d  = sh_d[IDX_W-1:0];
            cnt_d  = '0;
            dcnt_d = '0;
            state_d = (opcode_q == OP_READ) ? ST_RD_DATA :
                      (opcode_q == OP_QPP)  ? ST_WR_DATA : ST_DUMMY;
          end
        end
        ST_DUMMY: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DUMMY_CYC - 1)) state_d = ST_RD_DATA;
        end
        ST_WR_DATA: begin
          if (!dcnt_q[0]) begin
            dbyte_d[3:0] = io_s;
            dcnt_d       = 3'd1;
          end else begin
            mem_we   = 1'b1;
            dcnt_d   = 3'd0;
            idx_d    = page_next;
            wr_any_d = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (sclk_fall && (state_q == ST_STATUS || state_q == ST_RD_DATA)) begin
      if (state_q == ST_RD_DATA && addr_quad) begin
        io_oe_d = 4'hF;
        if (!dcnt_q[0]) begin
          io_out_d = rd_byte[7:4];
          dbyte_d  = rd_byte;
          dcnt_d   = 3'd1;
        end else begin
          io_out_d = dbyte_q[3:0];
          dcnt_d   = 3'd0;
          idx_d    = idx_q + IDX_W'(1);
        end
      end else begin
        src      = (state_q == ST_STATUS) ? {6'b0, wel_q, wip} : rd_byte;
        obyte    = (dcnt_q == 3'd0) ? src : dbyte_q;
        io_out_d = {2'b00, obyte[7], 1'b0};
        io_oe_d  = 4'b0010;
        dbyte_d  = {obyte[6:0], 1'b0};
        dcnt_d   = dcnt_q + 3'd1;
        if (state_q == ST_RD_DATA && dcnt_q == 3'd7) idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // NOTE: state is registered only with non-blocking assignments so every
  // flop samples the same pre-edge values.
  always_ff @(posedge h_clk) begin
    if (h_rst) begin
      state_q     <= ST_IDLE;
      opcode_q    <= '0;
      cnt_q       <= '0;
      addr_last_q <= '0;
      sh_q        <= '0;
      idx_q       <= '0;
      dbyte_q     <= '0;
      dcnt_q      <= '0;
      io_out_q    <= '0;
      io_oe_q     <= '0;
      busy_q      <= '0;
      wr_any_q    <= 1'b0;
      wel_q       <= 1'b0;
      addr4_q     <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      cnt_q       <= cnt_d;
      addr_last_q <= addr_last_d;
      sh_q        <= sh_d;
      idx_q       <= idx_d;
      dbyte_q     <= dbyte_d;
      dcnt_q      <= dcnt_d;
      io_out_q    <= io_out_d;
      io_oe_q     <= io_oe_d;
      busy_q      <= busy_d;
      wr_any_q    <= wr_any_d;
      wel_q       <= wel_d;
      addr4_q     <= addr4_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // NOTE: the byte array has no reset; only the per-byte programmed flags do.
  always_ff @(posedge h_clk) begin
    if (mem_we) mem_q[idx_q] <= mem_wd;
  end

  always_ff @(posedge h_clk) begin
    if (h_rst)       vld_q        <= '0;
    else if (mem_we) vld_q[idx_q] <= 1'b1;
  end

  assign io_out         = io_out_q;
  assign io_oe          = io_oe_q;
  assign addr4_mode_out = addr4_q;
  assign wel_out        = wel_q;
  assign wip_out        = wip;
  assign cmd_err_out    = cmd_err_q;

endmodule

// File: doc/qspi_flash_responder.md
Name: qspi_flash_responder

Overview:
- Synthesizable QSPI target (flash-device side) answering the commands our QSPI host controller issues.
- Used as the bench/FPGA end-point for the controller and as a loop-back responder in SoC tests.
- Oversamples the serial bus (sclk_in, cs_n_in, io_in) on the system clock and decodes command, address, dummy and data phases.
- Serves reads from, and accepts programs into, an internal byte array.

Parameters:
- MEM_BYTES, 256, byte-array depth; power of two.
- IDX_W, 8, log2(MEM_BYTES); address bits above IDX_W are ignored.
- DUMMY_CYC, 8, dummy sclk cycles for quad reads.
- BUSY_CYC, 64, h_clk cycles WIP stays set after a program (feature-gated).

Ports:
- h_clk  in  1  system clock; must be ≥8× sclk_in frequency.
- h_rst  in  1  synchronous, active-high reset.
- sclk_in  in  1  serial clock from host, mode 0 (CPOL=0, CPHA=0).
- cs_n_in  in  1  chip select, active low.
- io_in  in  4  io3..io0 from host.
- io_out  out  4  io3..io0 driven to host.
- io_oe  out  4  per-line output enable.
- addr4_mode_out  out  1  4-byte address mode active.
- wel_out  out  1  write-enable latch.
- wip_out  out  1  program in progress.
- cmd_err_out  out  1  one-h_clk pulse on unsupported opcode.

Behaviour:
- One clock (h_clk); reset is synchronous and active-high (h_rst). All outputs reset to 0; FSM→IDLE; addr4_mode, wel, wip cleared. Memory array is not reset; simulation initial content is 0xFF.
- Synchronizers: 2-flop on sclk_in, cs_n_in, io_in. Rise/fall detect on synced sclk. All bus events below are in synced time.
- Sampling and driving: sample on sclk rise, update io_out on sclk fall. Bit order is MSB first; in quad phases io3 carries the nibble MSB.
- Opcodes (always 1-line on io0):
  - 0x06 WREN: sets wel.
  - 0xB7 EN4B: sets addr4_mode.
  - 0x05 RDSR: status {6'b0, wel, wip} on io1, repeated until CS rises.
  - 0x03 READ: 1-line address on io0, no dummy, data on io1.
  - 0xEB QREAD: quad address, DUMMY_CYC dummy cycles, quad data.
  - 0xEC 4QREAD: as 0xEB, always 4-byte address.
  - 0x38 QPP: quad address, quad data in. Ignored (state → IGNORE) if wel=0.
  - Any other opcode: cmd_err_out pulse, then IGNORE.
- Address length: 3 bytes, or 4 bytes when addr4_mode=1 or opcode=0xEC. Memory index = addr[IDX_W-1:0].
- FSM states: IDLE → CMD (CS fall) → {ADDR, STATUS, IGNORE} → DUMMY → RD_DATA | WR_DATA.
  - CMD: after 8 rises, decode.
  - ADDR: 8×bytes rises (1-line) or 2×bytes rises (quad).
  - DUMMY: counts DUMMY_CYC rises. The first data nibble is driven on the fall after the last dummy rise, with io_oe=4'hF.
  - 0x03: io_oe=4'b0010 from the fall after the last address rise.
  - RD_DATA: after each byte, index increments and wraps at MEM_BYTES. Reads are unbounded.
  - WR_DATA: each completed byte does mem[idx] &= byte (flash AND semantics). Index wraps within the 256-byte page window of idx. A partial byte at CS rise is discarded.
- CS rise in any state → IDLE in the next h_clk; io_oe=0 that cycle. This is the only mid-transfer abort.
- CS rise after a QPP that completed ≥1 byte clears wel and sets wip. Program data issued with wip=1 is ignored.
- h_rst during a transfer: immediate IDLE. The host must re-assert CS before the next transfer is recognised.
- Simultaneous sclk edge and CS rise: CS wins; the edge is ignored.

Optional Feature:
- QSPI_RESP_WIP_EN
  - Defined: wip stays 1 for BUSY_CYC h_clk after the program's CS rise, then clears. During this window QREAD/READ return 0xFF and QPP is ignored.
  - Undefined: wip is tied 0; programs take effect immediately and BUSY_CYC is unused.

Decomposition:
- Shared package qspi_pkg:
  - Opcode constants (OP_WREN, OP_EN4B, OP_RDSR, OP_READ, OP_QREAD, OP_4QREAD, OP_QPP).
  - Responder state enum.
  - Phase-width localparams.
  - The same opcodes are reused by the host-side command select.
- Sub-module qspi_bus_sync: synchronizers plus sclk/cs edge detect.

Test Plan:
- WREN, then QPP at 0x000010 with bytes 0xA5, 0x3C → QREAD 0x000010 returns 0xA5, 0x3C; wel_out=0 after CS rise.
- QPP of 0x0F over existing 0xA5 → read returns 0x05 (AND semantics).
- EN4B, then 0xEB with address 0x000000FF, 3 bytes read → addr4_mode_out=1; 4-byte address accepted; data from 0xFF, 0x00, 0x01 (wrap).
- RDSR right after a QPP, with QSPI_RESP_WIP_EN defined → io1 shifts 0x01 until BUSY_CYC elapses, then 0x00. With the macro undefined → 0x00.
- Opcode 0x9F → cmd_err_out pulses once; io_oe stays 0 until CS rises.
- CS rise after 3 quad data nibbles of QPP → only the first byte is written; the partial nibble is discarded; FSM returns to IDLE.
